// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-2 Booth sequential multiplier.
//   state_t        : control FSM encoding (IDLE / RUN / DONE)
//   op_t           : Booth step operation (no-op / add M / subtract M)
//   booth_decode() : maps the {q[0], q_m1} bit pair onto a Booth operation
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } op_t;

  // Radix-2 Booth recoding: a 0->1 transition in the multiplier (reading
  // right to left) starts a run of ones and subtracts M; the 1->0 transition
  // ending the run adds M back. Inside a run of zeros or of ones, nothing is done.
  function automatic op_t booth_decode(input logic q0, input logic q_m1);
    op_t op;
    case ({q0, q_m1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// ---------------------------------------------------------------------------
// booth_addsub
// Combinational W-bit ripple-carry adder/subtractor.
//   x   : input  [W-1:0]  first operand
//   y   : input  [W-1:0]  second operand
//   sub : input           1 -> s = x - y, 0 -> s = x + y
//   s   : output [W-1:0]  result, modulo 2^W (carry out is discarded)
// Subtraction is x + ~y + 1: y is inverted bitwise and sub is the carry-in.
// ---------------------------------------------------------------------------
module booth_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s
);

  logic [W-1:0] w_y_eff;
  logic [W-1:0] w_carry;

  assign w_y_eff  = y ^ {W{sub}};
  assign w_carry[0] = sub;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi = gi + 1) begin : g_fa
      assign s[gi] = x[gi] ^ w_y_eff[gi] ^ w_carry[gi];
      // The carry out of the top bit is not needed: the width already
      // covers every intermediate Booth value.
      if (gi < W - 1) begin : g_carry
        assign w_carry[gi+1] = (x[gi] & w_y_eff[gi]) |
                               (x[gi] & w_carry[gi]) |
                               (w_y_eff[gi] & w_carry[gi]);
      end
    end
  endgenerate

endmodule

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
// Sequential signed multiplier, radix-2 Booth, one step per clock.
//   clk   : input           rising-edge clock
//   rst   : input           synchronous active-high reset (aborts a run)
//   start : input           request a multiply; only looked at in IDLE
//   a     : input  [N-1:0]  multiplicand M, two's complement
//   b     : input  [N-1:0]  multiplier Q, two's complement
//   busy  : output          high during the N iteration cycles
//   done  : output          one-cycle strobe; p holds the new product
//   p     : output [2N-1:0] registered signed product
// The accumulator is N+1 bits wide so that +/-M never overflows, which
// keeps the product exact even for (-2^(N-1)) * (-2^(N-1)).
// ---------------------------------------------------------------------------
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);

  state_t           r_state;
  logic [N:0]       r_acc;
  logic [N:0]       r_m;
  logic [N-1:0]     r_q;
  logic             r_qm1;
  logic [CW-1:0]    r_count;
  logic [2*N-1:0]   r_p;
  logic             r_busy;
  logic             r_done;

  op_t              w_op;
  logic             w_sub;
  logic [N:0]       w_addsub;
  logic [N:0]       w_sum;
  logic [N:0]       w_acc_sh;
  logic [N-1:0]     w_q_sh;
  logic             w_qm1_sh;

  // ---------------- one Booth step ----------------
  assign w_op  = booth_decode(r_q[0], r_qm1);
  assign w_sub = (w_op == OP_SUB);

  booth_addsub #(
    .W (N + 1)
  ) u_addsub (
    .x   (r_acc),
    .y   (r_m),
    .sub (w_sub),
    .s   (w_addsub)
  );

  assign w_sum = (w_op == OP_NOP) ? r_acc : w_addsub;

  // Arithmetic right shift of the concatenation {sum, q, q_m1}.
  assign w_acc_sh = {w_sum[N], w_sum[N:1]};
  assign w_q_sh   = {w_sum[0], r_q[N-1:1]};
  assign w_qm1_sh = r_q[0];

  // ---------------- control FSM and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_count <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= {a[N-1], a};
            r_q     <= b;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_count <= CW'(N);
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_acc   <= w_acc_sh;
          r_q     <= w_q_sh;
          r_qm1   <= w_qm1_sh;
          r_count <= r_count - 1'b1;
          // Last step: the low 2N bits of {acc, q} after the shift are the
          // product; acc's extra top bit is only a sign copy by now.
          if (r_count == CW'(1)) begin
            r_p     <= {w_acc_sh[N-1:0], w_q_sh};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

// File: tb/tb_booth_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq
// Two instances (N=8 with directed + random work, N=5 with random work)
// share clk/rst. A cycle-level reference model built from plain signed
// multiplication and an "edges since accept" counter predicts busy, done
// and p for both every cycle.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        st8 = 1'b0;
  logic [7:0]  a8  = '0;
  logic [7:0]  b8  = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  logic        st5 = 1'b0;
  logic [4:0]  a5  = '0;
  logic [4:0]  b5  = '0;
  logic        busy5;
  logic        done5;
  logic [9:0]  p5;

  int n_checks = 0;
  int n_errors = 0;
  int n_done5  = 0;
  bit chk_en   = 1'b0;
  bit fin5     = 1'b0;

  always #5 clk = ~clk;

  booth_mul_seq #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  booth_mul_seq #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .start(st5), .a(a5), .b(b5),
    .busy(busy5), .done(done5), .p(p5)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed product of two n-bit two's-complement values.
  function automatic longint ref_mul(input longint x, input longint y, input int n);
    longint sx, sy, full;
    full = longint'(1) << n;
    sx = x & (full - 1);
    sy = y & (full - 1);
    if (sx >= (full >> 1)) sx -= full;
    if (sy >= (full >> 1)) sy -= full;
    return sx * sy;
  endfunction

  function automatic longint mask2n(input longint v, input int n);
    return v & ((longint'(1) << (2 * n)) - 1);
  endfunction

  // ---------------- reference model ----------------
  bit     m_idle [2] = '{1'b1, 1'b1};
  int     m_age  [2] = '{0, 0};
  longint m_pend [2] = '{0, 0};
  longint m_p    [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int     n;
      bit     s;
      longint xa, xb;
      n  = (i == 0) ? 8 : 5;
      s  = (i == 0) ? st8 : st5;
      xa = (i == 0) ? longint'(a8) : longint'(a5);
      xb = (i == 0) ? longint'(b8) : longint'(b5);
      if (rst) begin
        m_idle[i] = 1'b1;
        m_age[i]  = 0;
        m_p[i]    = 0;
      end else if (m_idle[i]) begin
        if (s) begin
          m_idle[i] = 1'b0;
          m_age[i]  = 0;
          m_pend[i] = mask2n(ref_mul(xa, xb, n), n);
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == n)     m_p[i]    = m_pend[i];
        if (m_age[i] == n + 1) m_idle[i] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", 64'(busy8), 64'(!m_idle[0] && m_age[0] < 8));
      chk("done8", 64'(done8), 64'(!m_idle[0] && m_age[0] == 8));
      chk("p8",    64'(p8),    64'(m_p[0]));
      chk("busy5", 64'(busy5), 64'(!m_idle[1] && m_age[1] < 5));
      chk("done5", 64'(done5), 64'(!m_idle[1] && m_age[1] == 5));
      chk("p5",    64'(p5),    64'(m_p[1]));
      if (done5) n_done5++;
    end
  end

  // ---------------- N=8 helpers ----------------
  task automatic wait_idle8();
    for (int k = 0; k < 30 && (busy8 || done8); k++) @(negedge clk);
    chk("idle8_timeout", 64'(busy8 | done8), 64'd0);
  endtask

  // One complete multiply starting from IDLE; checks latency, busy length
  // and the product against a literal expectation.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp, input string nm);
    int  nbusy, lat;
    bit  got;
    @(negedge clk);
    a8 = ta; b8 = tb; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    nbusy = 0; lat = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (busy8) nbusy++;
      if (done8) begin got = 1'b1; lat = k; end
      if (!got) @(negedge clk);
    end
    $display("op8 %s: a=%0d b=%0d p=%h", nm, $signed(ta), $signed(tb), p8);
    chk({nm, "_latency"}, 64'(lat), 64'd9);
    chk({nm, "_busy_cycles"}, 64'(nbusy), 64'd8);
    chk({nm, "_p"}, 64'(p8), 64'(exp));
  endtask

  // ---------------- N=5 random driver ----------------
  initial begin
    wait (chk_en);
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (k < 20) begin
        a5 = 5'h10; b5 = 5'h10;
      end else begin
        a5 = 5'($urandom); b5 = 5'($urandom);
      end
      st5 = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    st5  = 1'b0;
    fin5 = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int prev, ndone;
    bit seen;

    // Model pins: hand-computed products.
    chk("ref_m128sq", 64'(ref_mul(128, 128, 8)), 64'd16384);
    chk("ref_3xm5",   64'(mask2n(ref_mul(3, 251, 8), 8)), 64'hFFF1);
    chk("ref5_m16sq", 64'(ref_mul(16, 16, 5)), 64'd256);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_p",    64'(p8),    64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    op8(8'd3,   8'hFB, 16'hFFF1, "3x-5");
    op8(8'h80,  8'h80, 16'h4000, "-128x-128");
    op8(8'd127, 8'd127, 16'h3F01, "127x127");
    op8(8'h80,  8'd127, 16'hC080, "-128x127");
    op8(8'd0,   8'hFF, 16'h0000, "0x-1");
    op8(8'd1,   8'h80, 16'hFF80, "1x-128");

    // start held high: one product every N+2 cycles, operands changing
    // every cycle but only sampled at accepting edges.
    @(negedge clk);
    st8 = 1'b1; prev = -1; ndone = 0;
    for (int k = 0; k < 45; k++) begin
      if (done8) begin
        if (prev >= 0) chk("held_period", 64'(k - prev), 64'd10);
        prev = k;
        ndone++;
      end
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    st8 = 1'b0;
    $display("held start: %0d products", ndone);
    chk("held_count", 64'(ndone >= 4), 64'd1);

    // start during RUN is ignored.
    wait_idle8();
    a8 = 8'd7; b8 = 8'd6; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd5; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done8) seen = 1'b1; else @(negedge clk);
    end
    $display("ignore-start: p=%0d", p8);
    chk("ignore_seen", 64'(seen), 64'd1);
    chk("ignore_p", 64'(p8), 64'd42);

    // Reset at RUN step 4 aborts without a done pulse.
    wait_idle8();
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd6; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;       // after edge 0
    @(negedge clk);                   // after edge 1
    @(negedge clk);                   // after edge 2
    @(negedge clk);                   // after edge 3
    rst = 1'b1;
    @(negedge clk);                   // after edge 4 (reset edge)
    rst = 1'b0;
    $display("abort: busy=%0b done=%0b p=%h", busy8, done8, p8);
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_p",    64'(p8),    64'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done8) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    op8(8'd6, 8'hF9, 16'hFFD6, "6x-7");

    // Random sweep on N=8 with random idle gaps.
    for (int t = 0; t < 60; t++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom); rb = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op8(ra, rb, 16'(mask2n(ref_mul(longint'(ra), longint'(rb), 8), 8)), "rand8");
    end

    for (int k = 0; k < 3000 && !fin5; k++) @(negedge clk);
    chk("fin5_timeout", 64'(fin5), 64'd1);
    repeat (12) @(negedge clk);
    $display("N=5 sweep: %0d products", n_done5);
    chk("n5_products", 64'(n_done5 >= 20), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
